// File: rtl/highpass_ctrl.sv
// highpass_ctrl: sequencing controller for the shared highpass datapath.
// Feeds one sample per 3-clock frame into the filter, debounces the cutoff
// selector, and applies each cutoff change under a mute ramp
// (ramp down, switch, flush, ramp up) so switching never clicks.
// Optional feature macro: HIGHPASS_BYPASS_EN (filter code 0 = bypass).
module highpass_ctrl #(
  parameter logic [2:0] RESET_FILTER = 3'd3,
  parameter int         DEBOUNCE     = 8,
  parameter int         STEP         = 16,
  parameter int         FLUSH        = 32
) (
  input  logic               clk_144,
  input  logic               reset_n,
  input  logic        [2:0]  filter_req,
  input  logic signed [15:0] audioIn,
  input  logic signed [15:0] highpassOut,
  output logic        [2:0]  filter,
  output logic signed [15:0] highpassIn,
  output logic signed [15:0] audioOut,
  output logic               busy
);

  localparam logic [7:0] DEB_MAX = DEBOUNCE[7:0];
  localparam logic [8:0] STEP_G  = STEP[8:0];
  localparam logic [7:0] FLUSH_N = FLUSH[7:0];
  localparam logic [8:0] UNITY   = 9'd256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP_DOWN,
    ST_SWITCH,
    ST_FLUSH,
    ST_RAMP_UP
  } state_t;

  state_t state;

  logic [1:0] ph;
  logic       boundary;

  logic [2:0] req_q;
  logic [2:0] target;
  logic [2:0] target_nxt;
  logic [7:0] deb_cnt;
  logic       stable;

  logic [8:0] gain;
  logic [8:0] gain_dn;
  logic [8:0] gain_up;
  logic [9:0] gain_sum;
  logic [7:0] flush_cnt;
  logic [7:0] flush_nxt;

  logic signed [15:0] src;
  logic signed [24:0] src_ext;
  logic signed [24:0] gain_ext;
  logic signed [24:0] prod;
  logic signed [24:0] shifted;
  logic signed [15:0] sat;

  assign boundary = (ph == 2'd2);

  // Sample phase counter: 0 -> 1 -> 2 -> 0, phase 2 is the sample boundary.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      ph <= 2'd0;
    end else if (boundary) begin
      ph <= 2'd0;
    end else begin
      ph <= ph + 2'd1;
    end
  end

  // Register the incoming sample into the datapath at phase 0.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      highpassIn <= '0;
    end else if (ph == 2'd0) begin
      highpassIn <= audioIn;
    end
  end

  // Selector debounce: the code must hold still for DEBOUNCE samples before it becomes the target.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= RESET_FILTER;
      deb_cnt <= '0;
      target  <= RESET_FILTER;
    end else if (boundary) begin
      req_q <= filter_req;
      if (filter_req != req_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_MAX) begin
        deb_cnt <= deb_cnt + 8'd1;
      end
      if (stable) begin
        target <= req_q;
      end
    end
  end

  // The sequencer looks at the target as it stands after this boundary, so a freshly
  // accepted code starts the ramp in the same sample it is accepted.
  always_comb begin
    stable     = (deb_cnt == DEB_MAX);
    target_nxt = stable ? req_q : target;
  end

  // Next gain values for the two ramp directions, floored at mute and capped at unity.
  always_comb begin
    gain_sum  = {1'b0, gain} + {1'b0, STEP_G};
    gain_up   = (gain_sum >= {1'b0, UNITY}) ? UNITY : gain_sum[8:0];
    gain_dn   = (gain > STEP_G) ? (gain - STEP_G) : 9'd0;
    flush_nxt = flush_cnt + 8'd1;
  end

  // Change sequencer: one transition per sample boundary, all outputs registered.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      gain      <= UNITY;
      filter    <= RESET_FILTER;
      flush_cnt <= '0;
      busy      <= 1'b0;
    end else if (boundary) begin
      case (state)
        ST_IDLE: begin
          gain <= UNITY;
          if (target_nxt != filter) begin
            state <= ST_RAMP_DOWN;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_RAMP_DOWN: begin
          gain <= gain_dn;
          busy <= 1'b1;
          if (gain_dn == 9'd0) begin
            state <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          gain      <= 9'd0;
          filter    <= target_nxt;
          flush_cnt <= '0;
          busy      <= 1'b1;
          state     <= ST_FLUSH;
        end
        ST_FLUSH: begin
          gain      <= 9'd0;
          flush_cnt <= flush_nxt;
          busy      <= 1'b1;
          if (flush_nxt == FLUSH_N) begin
            state <= ST_RAMP_UP;
          end
        end
        ST_RAMP_UP: begin
          if (target_nxt != filter) begin
            state <= ST_RAMP_DOWN;
            busy  <= 1'b1;
          end else begin
            gain <= gain_up;
            if (gain_up == UNITY) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              busy <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          gain  <= UNITY;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Gain scaling: 25-bit signed product, arithmetic shift by 8, saturate to 16 bits.
  always_comb begin
`ifdef HIGHPASS_BYPASS_EN
    src = (filter == 3'd0) ? highpassIn : highpassOut;
`else
    src = highpassOut;
`endif
    src_ext  = {{9{src[15]}}, src};
    gain_ext = {16'd0, gain};
    prod     = src_ext * gain_ext;
    shifted  = prod >>> 8;
    if (shifted > 25'sd32767) begin
      sat = 16'sd32767;
    end else if (shifted < -25'sd32768) begin
      sat = -16'sd32768;
    end else begin
      sat = shifted[15:0];
    end
  end

  // Output sample updates only at the boundary, one clock after highpassOut is sampled.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      audioOut <= '0;
    end else if (boundary) begin
      audioOut <= sat;
    end
  end

endmodule

// File: tb/tb_highpass_ctrl.sv
// tb_highpass_ctrl: self-checking bench for highpass_ctrl.
// Expected outputs come from a timeline of the change sequence derived from
// the default parameters; each sample pushes its expectation to a scoreboard
// queue and pops it when the DUT finishes that sample.
module tb_highpass_ctrl;

  localparam int STP     = 16;
  localparam int DEB     = 8;
  localparam int FL      = 32;
  localparam int RAMP    = 256 / STP;
  localparam int BUSY_AT = DEB + 1;
  localparam int G_ZERO  = BUSY_AT + RAMP;
  localparam int SW_AT   = G_ZERO + 1;
  localparam int UP_AT   = SW_AT + FL;
  localparam int IDLE_AT = UP_AT + RAMP;
  localparam int REV_AT  = UP_AT + DEB + 1;
  localparam int REV_G   = STP * (REV_AT - 1 - UP_AT);
  localparam int REV_Z   = REV_AT + REV_G / STP;
  localparam int SW2_AT  = REV_Z + 1;
  localparam int UP2_AT  = SW2_AT + FL;
  localparam int IDLE2   = UP2_AT + RAMP;

`ifdef HIGHPASS_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  logic               clk_144 = 1'b0;
  logic               reset_n;
  logic        [2:0]  filter_req;
  logic signed [15:0] audioIn;
  logic signed [15:0] highpassOut;
  logic        [2:0]  filter;
  logic signed [15:0] highpassIn;
  logic signed [15:0] audioOut;
  logic               busy;

  typedef struct {
    logic signed [31:0] aout;
    logic signed [31:0] bsy;
    logic signed [31:0] filt;
  } exp_t;

  exp_t sb[$];
  int   testCount = 0;
  int   failCount = 0;

  highpass_ctrl dut (
    .clk_144    (clk_144),
    .reset_n    (reset_n),
    .filter_req (filter_req),
    .audioIn    (audioIn),
    .highpassOut(highpassOut),
    .filter     (filter),
    .highpassIn (highpassIn),
    .audioOut   (audioOut),
    .busy       (busy)
  );

  // Free-running system clock.
  always #5 clk_144 = ~clk_144;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int modelOut(input int ain, input int hpo, input int g, input int fPrev);
    int src;
    int q;
    src = hpo;
    if (BYPASS_ON && fPrev == 0) src = ain;
    q = (src * g) >>> 8;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  // Timeline of gain / busy / filter after boundary n of a scenario.
  // kind 0: steady, kind 1: single change, kind 2: change reversed at gain 128 on the ramp up.
  task automatic sched(input int kind, input int n, input int oldF, input int midF,
                       input int newF, output int g, output int b, output int f);
    g = 256;
    b = 0;
    f = oldF;
    if (kind == 1 || (kind == 2 && n < REV_AT)) begin
      if (n <= BUSY_AT) g = 256;
      else if (n <= G_ZERO) g = 256 - STP * (n - BUSY_AT);
      else if (n <= UP_AT) g = 0;
      else if (n <= IDLE_AT) g = STP * (n - UP_AT);
      else g = 256;
      b = (n >= BUSY_AT && n < IDLE_AT) ? 1 : 0;
      f = (n >= SW_AT) ? ((kind == 2) ? midF : newF) : oldF;
    end else if (kind == 2) begin
      if (n == REV_AT) g = REV_G;
      else if (n <= REV_Z) g = REV_G - STP * (n - REV_AT);
      else if (n <= UP2_AT) g = 0;
      else if (n <= IDLE2) g = STP * (n - UP2_AT);
      else g = 256;
      b = (n < IDLE2) ? 1 : 0;
      f = (n >= SW2_AT) ? newF : midF;
    end
  endtask

  // Drive one sample frame and check the outputs at the end of its boundary.
  task automatic applyStimulus(input logic [2:0] req, input logic signed [15:0] ain,
                               input logic signed [15:0] hpo, input int gPrev, input int fPrev,
                               input int bExp, input int fExp);
    exp_t e;
    filter_req = req;
    audioIn    = ain;
    e.aout = modelOut(ain, hpo, gPrev, fPrev);
    e.bsy  = bExp;
    e.filt = fExp;
    sb.push_back(e);
    @(posedge clk_144);
    #1;
    checkOutput("highpassIn", highpassIn, ain);
    highpassOut = hpo;
    @(posedge clk_144);
    @(posedge clk_144);
    #1;
    e = sb.pop_front();
    checkOutput("audioOut", audioOut, e.aout);
    checkOutput("busy", {31'd0, busy}, e.bsy);
    checkOutput("filter", {29'd0, filter}, e.filt);
  endtask

  task automatic runScenario(input int kind, input int count, input int oldF, input int midF,
                             input int newF, input logic [2:0] reqA, input logic [2:0] reqB,
                             input int reqBAt, input int satUntil);
    int gPrev, bPrev, fPrev, gNow, bNow, fNow;
    logic signed [15:0] ain;
    logic signed [15:0] hpo;
    for (int n = 0; n < count; n++) begin
      sched(kind, n - 1, oldF, midF, newF, gPrev, bPrev, fPrev);
      sched(kind, n, oldF, midF, newF, gNow, bNow, fNow);
      ain = 16'($urandom);
      hpo = (n < satUntil) ? -16'sd32768 : 16'($urandom);
      applyStimulus((n >= reqBAt) ? reqB : reqA, ain, hpo, gPrev, fPrev, bNow, fNow);
      if (n == 0 && satUntil > 0) checkOutput("sat_gain256", audioOut, -32768);
      if (n == BUSY_AT + 2 && satUntil > BUSY_AT + 2) checkOutput("sat_gain240", audioOut, -30720);
      if (BYPASS_ON && fPrev == 0 && gPrev == 256) checkOutput("bypass", audioOut, ain);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    filter_req  = 3'd3;
    audioIn     = '0;
    highpassOut = '0;
    repeat (2) @(posedge clk_144);
    #1;
    checkOutput("reset_filter", {29'd0, filter}, 3);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_audioOut", audioOut, 0);
    checkOutput("reset_highpassIn", highpassIn, 0);
    @(negedge clk_144);
    reset_n = 1'b1;

    $display("[TB] steady state, filter_req=3");
    runScenario(0, 20, 3, 3, 3, 3'd3, 3'd3, 0, 0);

    $display("[TB] glitch to 6 for 5 samples");
    runScenario(0, 25, 3, 3, 3, 3'd6, 3'd3, 5, 0);

    $display("[TB] single change 3 -> 5");
    runScenario(1, 80, 3, 3, 5, 3'd5, 3'd5, 0, 0);

    $display("[TB] change 5 -> 6 reversed to 2 on the ramp up, saturated input at start");
    runScenario(2, 130, 5, 6, 2, 3'd6, 3'd2, UP_AT, 13);

    $display("[TB] change 2 -> 7 with reset during flush");
    runScenario(1, 41, 2, 2, 7, 3'd7, 3'd7, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midflush_filter", {29'd0, filter}, 3);
    checkOutput("midflush_busy", {31'd0, busy}, 0);
    checkOutput("midflush_audioOut", audioOut, 0);
    filter_req = 3'd3;
    @(negedge clk_144);
    reset_n = 1'b1;
    runScenario(0, 12, 3, 3, 3, 3'd3, 3'd3, 0, 0);

`ifdef HIGHPASS_BYPASS_EN
    $display("[TB] bypass request 3 -> 0");
    runScenario(1, 85, 3, 3, 0, 3'd0, 3'd0, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
